// File: rtl/draw_menu_select_if.sv
// vga_if: one VGA pixel-stream beat (raster position, sync/blank flags, 12-bit rgb).
//   in  modport: consumer side, every field is an input
//   out modport: producer side, every field is an output
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_menu_select.sv
// draw_menu_select: menu overlay stage of the VGA pipeline.
// While state == ACTIVE_STATE it paints N_OPT stacked option boxes. It moves a cursor
// with up/down buttons, blinks the highlighted box, and reports the cursor on select.
// In any other state the pixel stream goes through unchanged. Every output is
// registered, so the stage adds one cycle of latency.
//
// Ports:
//   clk           pixel clock
//   rst           asynchronous, active-high reset
//   state[2:0]    game FSM state
//   btn_up        debounced level, synchronous to clk
//   btn_down      debounced level, synchronous to clk
//   btn_sel       debounced level, synchronous to clk
//   vga_menu_in   incoming timing + rgb
//   vga_menu_out  outgoing timing + rgb, one cycle later
//   sel_idx       cursor value captured on select, held until the next select
//   sel_valid     one-cycle pulse on select
module draw_menu_select #(
  parameter int          N_OPT        = 3,
  parameter int          X0           = 412,
  parameter int          Y0           = 300,
  parameter int          BOX_W        = 200,
  parameter int          BOX_H        = 40,
  parameter int          GAP          = 20,
  parameter logic [11:0] COL_BOX      = 12'h4_4_4,
  parameter logic [11:0] COL_SEL      = 12'hf_a_5,
  parameter int          BLINK_FRAMES = 30,
  parameter bit          WRAP         = 1'b1,
  parameter logic [2:0]  ACTIVE_STATE = 3'd0,
  localparam int         IDX_W        = (N_OPT > 1) ? $clog2(N_OPT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       state,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_sel,
  vga_if.in                vga_menu_in,
  vga_if.out               vga_menu_out,
  output logic [IDX_W-1:0] sel_idx,
  output logic             sel_valid
);

  localparam int               CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OPT - 1);
  localparam logic [10:0]      X_LO     = 11'(X0);
  localparam logic [10:0]      X_HI     = 11'(X0 + BOX_W - 1);

  logic [IDX_W-1:0] cursor;
  logic [IDX_W-1:0] cursor_nx;
  logic [IDX_W-1:0] cur_eff;
  logic [IDX_W-1:0] drawn_cur;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_on;
  logic             up_prev, down_prev, sel_prev;
  logic             vblnk_prev;
  logic             active_prev;

  logic             active;
  logic             entering;
  logic             up_e, down_e, sel_e;
  logic             frame_rise;
  logic             in_x;
  logic [N_OPT-1:0] hit_y;
  logic [N_OPT-1:0] hit_sel;
  logic             in_box;
  logic             on_sel;
  logic [11:0]      rgb_nx;

  assign active     = (state == ACTIVE_STATE);
  assign entering   = active && !active_prev;
  assign up_e       = btn_up   & ~up_prev;
  assign down_e     = btn_down & ~down_prev;
  assign sel_e      = btn_sel  & ~sel_prev;
  assign frame_rise = vga_menu_in.vblnk & ~vblnk_prev;

  // All boxes share one horizontal span, so the x test is done once and each box
  // only needs its own pair of vertical comparators.
  assign in_x = (vga_menu_in.hcount >= X_LO) && (vga_menu_in.hcount <= X_HI);

  for (genvar i = 0; i < N_OPT; i++) begin : g_box
    localparam logic [10:0] Y_LO = 11'(Y0 + i * (BOX_H + GAP));
    localparam logic [10:0] Y_HI = 11'(Y0 + i * (BOX_H + GAP) + BOX_H - 1);
    assign hit_y[i]   = (vga_menu_in.vcount >= Y_LO) && (vga_menu_in.vcount <= Y_HI);
    assign hit_sel[i] = hit_y[i] && (drawn_cur == IDX_W'(i));
  end

  assign in_box = in_x && (|hit_y);
  assign on_sel = in_x && (|hit_sel);

  always_comb begin
    rgb_nx = vga_menu_in.rgb;
    if (active && in_box) begin
      rgb_nx = (on_sel && blink_on) ? COL_SEL : COL_BOX;
    end
  end

  // On the cycle the menu is re-entered the cursor is forced to 0, and that
  // 0 is also what a coincident select reports.
  always_comb begin
    cursor_nx = cursor;
    cur_eff   = cursor;
    if (entering) begin
      cursor_nx = '0;
      cur_eff   = '0;
    end else if (active) begin
      if (up_e && !down_e) begin
        if (cursor == '0) begin
          cursor_nx = WRAP ? IDX_LAST : '0;
        end else begin
          cursor_nx = cursor - IDX_W'(1);
        end
      end else if (down_e && !up_e) begin
        if (cursor == IDX_LAST) begin
          cursor_nx = WRAP ? '0 : IDX_LAST;
        end else begin
          cursor_nx = cursor + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_prev     <= 1'b0;
      down_prev   <= 1'b0;
      sel_prev    <= 1'b0;
      vblnk_prev  <= 1'b0;
      active_prev <= 1'b0;
      cursor      <= '0;
      sel_idx     <= '0;
      sel_valid   <= 1'b0;
    end else begin
      up_prev     <= btn_up;
      down_prev   <= btn_down;
      sel_prev    <= btn_sel;
      vblnk_prev  <= vga_menu_in.vblnk;
      active_prev <= active;
      cursor      <= cursor_nx;
      sel_valid   <= active && sel_e;
      if (active && sel_e) begin
        sel_idx <= cur_eff;
      end
    end
  end

  // Frame-rate state: the highlight only changes at vblank so a box never
  // changes colour partway down the screen. This runs in every game state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drawn_cur <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_rise) begin
      drawn_cur <= cursor;
      if (blink_cnt == CNT_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_menu_out.vcount <= '0;
      vga_menu_out.vsync  <= 1'b0;
      vga_menu_out.vblnk  <= 1'b0;
      vga_menu_out.hcount <= '0;
      vga_menu_out.hsync  <= 1'b0;
      vga_menu_out.hblnk  <= 1'b0;
      vga_menu_out.rgb    <= '0;
    end else begin
      vga_menu_out.vcount <= vga_menu_in.vcount;
      vga_menu_out.vsync  <= vga_menu_in.vsync;
      vga_menu_out.vblnk  <= vga_menu_in.vblnk;
      vga_menu_out.hcount <= vga_menu_in.hcount;
      vga_menu_out.hsync  <= vga_menu_in.hsync;
      vga_menu_out.hblnk  <= vga_menu_in.hblnk;
      vga_menu_out.rgb    <= rgb_nx;
    end
  end

endmodule

// File: tb/tb_draw_menu_select.sv
module tb_draw_menu_select;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state = 3'd0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0;
  logic [1:0] sel_idx, sel_idx_nw;
  logic       sel_valid, sel_valid_nw;

  vga_if vin ();
  vga_if vout ();
  vga_if vout_nw ();

  draw_menu_select dut (
    .clk(clk), .rst(rst), .state(state),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .vga_menu_in(vin.in), .vga_menu_out(vout.out),
    .sel_idx(sel_idx), .sel_valid(sel_valid)
  );

  draw_menu_select #(.WRAP(1'b0)) dut_nw (
    .clk(clk), .rst(rst), .state(state),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .vga_menu_in(vin.in), .vga_menu_out(vout_nw.out),
    .sel_idx(sel_idx_nw), .sel_valid(sel_valid_nw)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [11:0] rgb;
    logic [11:0] rgb_nw;
    logic [10:0] h;
    logic [10:0] v;
    logic [3:0]  flags;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // bench model
  int m_cur = 0, m_cur_nw = 0;
  int m_drawn = 0, m_drawn_nw = 0;
  int m_frames = 0;
  int m_sel = 0, m_sel_nw = 0;

  int sel_cnt = 0, sel_cnt_nw = 0;
  always @(negedge clk) begin
    if (sel_valid)    sel_cnt++;
    if (sel_valid_nw) sel_cnt_nw++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_blink();
    return ((m_frames / 30) % 2) == 0;
  endfunction

  function automatic logic [11:0] exp_pix(int h, int v, logic [11:0] rin, bit act, int hl);
    if (!act) return rin;
    for (int i = 0; i < 3; i++) begin
      if (h >= 412 && h <= 611 && v >= 300 + 60 * i && v <= 339 + 60 * i)
        return (i == hl && m_blink()) ? 12'hfa5 : 12'h444;
    end
    return rin;
  endfunction

  task automatic check_px(input string tag, input int h, input int v, input logic [11:0] rin);
    exp_t e;
    bit act;
    logic [10:0] h11, v11;
    h11 = 11'(h);
    v11 = 11'(v);
    act = (state == 3'd0);
    vin.hcount = h11;
    vin.vcount = v11;
    vin.rgb    = rin;
    vin.hsync  = h11[0];
    vin.vsync  = v11[0];
    vin.hblnk  = h11[1];
    vin.vblnk  = 1'b0;
    e.tag    = tag;
    e.rgb    = exp_pix(h, v, rin, act, m_drawn);
    e.rgb_nw = exp_pix(h, v, rin, act, m_drawn_nw);
    e.h      = h11;
    e.v      = v11;
    e.flags  = {v11[0], h11[0], h11[1], 1'b0};
    exp_q.push_back(e);
    tick();
    e = exp_q.pop_front();
    chk({e.tag, ".rgb"},    vout.rgb,    e.rgb);
    chk({e.tag, ".rgb_nw"}, vout_nw.rgb, e.rgb_nw);
    chk({e.tag, ".hcount"}, vout.hcount, e.h);
    chk({e.tag, ".vcount"}, vout.vcount, e.v);
    chk({e.tag, ".flags"},  {vout.vsync, vout.hsync, vout.hblnk, vout.vblnk}, e.flags);
  endtask

  task automatic frame();
    vin.vblnk = 1'b1;
    tick();
    m_frames++;
    m_drawn    = m_cur;
    m_drawn_nw = m_cur_nw;
    vin.vblnk = 1'b0;
    tick();
  endtask

  task automatic press(input string tag, input bit up, input bit dn, input bit sel);
    int c0, c1;
    bit act;
    act = (state == 3'd0);
    c0 = sel_cnt;
    c1 = sel_cnt_nw;
    btn_up = up; btn_down = dn; btn_sel = sel;
    if (act) begin
      if (sel) begin
        m_sel = m_cur;
        m_sel_nw = m_cur_nw;
      end
      if (up && !dn) begin
        m_cur    = (m_cur == 0) ? 2 : m_cur - 1;
        m_cur_nw = (m_cur_nw == 0) ? 0 : m_cur_nw - 1;
      end else if (dn && !up) begin
        m_cur    = (m_cur == 2) ? 0 : m_cur + 1;
        m_cur_nw = (m_cur_nw == 2) ? 2 : m_cur_nw + 1;
      end
    end
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    tick();
    if (sel) begin
      chk({tag, ".sel_pulses"},    sel_cnt - c0,    (act ? 1 : 0));
      chk({tag, ".sel_pulses_nw"}, sel_cnt_nw - c1, (act ? 1 : 0));
      chk({tag, ".sel_idx"},       sel_idx,    m_sel);
      chk({tag, ".sel_idx_nw"},    sel_idx_nw, m_sel_nw);
    end
  endtask

  initial begin
    vin.hcount = '0; vin.vcount = '0; vin.rgb = '0;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;

    // 1: reset then default overlay geometry
    repeat (3) tick();
    chk("rst.rgb", vout.rgb, 12'h000);
    chk("rst.hcount", vout.hcount, 11'd0);
    chk("rst.sel_valid", sel_valid, 1'b0);
    chk("rst.sel_idx", sel_idx, 2'd0);
    rst = 1'b0;
    tick();
    frame();
    check_px("t1.box0", 500, 310, 12'h123);
    check_px("t1.box1", 500, 370, 12'h123);
    check_px("t1.gap", 500, 345, 12'h123);
    check_px("t1.left", 300, 310, 12'h123);
    check_px("t1.edge_l", 412, 300, 12'h0f0);
    check_px("t1.edge_r", 612, 300, 12'h0f0);
    check_px("t1.box2_bot", 611, 459, 12'h0f0);
    check_px("t1.below", 611, 460, 12'h0f0);

    // 2: cursor movement, wrap vs saturate, tear-free update
    press("t2.d1", 0, 1, 0);
    press("t2.d2", 0, 1, 0);
    check_px("t2.pre_vblnk", 500, 310, 12'h123);
    frame();
    check_px("t2.box2", 500, 430, 12'h123);
    check_px("t2.box0", 500, 310, 12'h123);
    press("t2.d3", 0, 1, 0);
    frame();
    check_px("t2.wrap0", 500, 310, 12'h123);
    check_px("t2.wrap0_b2", 500, 430, 12'h123);
    press("t2.up", 1, 0, 0);
    frame();
    check_px("t2.up_b2", 500, 430, 12'h123);
    check_px("t2.up_b1", 500, 370, 12'h123);

    // 3: select
    press("t3.up", 1, 0, 0);
    begin
      int c0, c1;
      c0 = sel_cnt; c1 = sel_cnt_nw;
      m_sel = m_cur; m_sel_nw = m_cur_nw;
      btn_sel = 1'b1;
      repeat (5) tick();
      btn_sel = 1'b0;
      tick();
      chk("t3.hold_pulses", sel_cnt - c0, 1);
      chk("t3.hold_pulses_nw", sel_cnt_nw - c1, 1);
      chk("t3.hold_idx", sel_idx, m_sel);
      chk("t3.hold_idx_nw", sel_idx_nw, m_sel_nw);
    end
    press("t3.sel_down", 0, 1, 1);
    frame();
    check_px("t3.after_b2", 500, 430, 12'h123);
    check_px("t3.after_b1", 500, 370, 12'h123);

    // 4: inactive state passes through and ignores buttons; re-entry resets cursor
    state = 3'd3;
    check_px("t4.pass_b0", 500, 310, 12'h7e1);
    check_px("t4.pass_b2", 500, 430, 12'h7e1);
    press("t4.down", 0, 1, 0);
    press("t4.sel", 0, 0, 1);
    frame();
    check_px("t4.pass_b1", 450, 380, 12'h321);
    state = 3'd0;
    m_cur = 0; m_cur_nw = 0;
    tick();
    check_px("t4.entry_old_b2", 500, 430, 12'h123);
    check_px("t4.entry_old_b1", 500, 370, 12'h123);
    frame();
    check_px("t4.entry_b0", 500, 310, 12'h123);
    check_px("t4.entry_b2", 500, 430, 12'h123);

    // 5: simultaneous up+down, then blink over 61+ frames
    press("t5.updown", 1, 1, 0);
    while (m_frames < 62) begin
      frame();
      check_px("t5.blink", 500, 310, 12'h123);
    end

    // 6: asynchronous reset with no clock edge
    check_px("t6.pre", 700, 123, 12'habc);
    #2 rst = 1'b1;
    #1;
    chk("t6.rgb", vout.rgb, 12'h000);
    chk("t6.hcount", vout.hcount, 11'd0);
    chk("t6.vcount", vout.vcount, 11'd0);
    chk("t6.flags", {vout.vsync, vout.hsync, vout.hblnk, vout.vblnk}, 4'd0);
    chk("t6.sel_idx", sel_idx, 2'd0);
    chk("t6.sel_valid", sel_valid, 1'b0);
    #1 rst = 1'b0;
    m_cur = 0; m_cur_nw = 0; m_drawn = 0; m_drawn_nw = 0; m_frames = 0;
    check_px("t6.post_b0", 500, 310, 12'h111);
    check_px("t6.post_pass", 3, 1, 12'h5a5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
